fc_mac_pe: RTL

FC_MAC_PE -- requirements
Module: fc_mac_pe

---
 rtl/fc_pe_pkg.sv | 28 ++
 rtl/fc_mac_lane.sv | 54 +++++
 rtl/fc_mac_pe.sv | 112 +++++++++++
 3 files changed

// File: rtl/fc_pe_pkg.sv
// Shared types and helpers for the fully-connected MAC processing element:
// FSM state encoding, accumulator sizing and output saturation.
package fc_pe_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      FINISH = 2'd2,
      HOLD   = 2'd3
   } fc_state_e;

   // Wide enough that N_IN full-scale products can never overflow.
   function automatic int acc_width(input int act_w, input int wt_w, input int n_in);
      return act_w + wt_w + $clog2(n_in) + 1;
   endfunction

   function automatic logic signed [127:0] sat_out(input logic signed [127:0] v,
                                                   input int out_w);
      logic signed [127:0] max_v;
      logic signed [127:0] min_v;
      max_v = (128'sd1 <<< (out_w - 1)) - 128'sd1;
      min_v = -(128'sd1 <<< (out_w - 1));
      if (v > max_v)      return max_v;
      else if (v < min_v) return min_v;
      else                return v;
   endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One output neuron: multiply, shift, accumulate, then bias/relu/saturate
// into a combinational result that the controller registers in FINISH.
module fc_mac_lane
   import fc_pe_pkg::*;
#(
   parameter int ACT_W = 18,
   parameter int WT_W  = 16,
   parameter int OUT_W = 16,
   parameter int FRAC  = 0,
   parameter int ACC_W = 43
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic                    add,
   input  logic signed [ACT_W-1:0] act,
   input  logic signed [WT_W-1:0]  wt,
   input  logic signed [OUT_W-1:0] bias,
   input  logic                    relu,
   output logic signed [OUT_W-1:0] res
);

   localparam int PW = ACT_W + WT_W;

   logic signed [PW-1:0]    prod;
   logic signed [PW-1:0]    prod_sh;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W:0]   sum;
   logic signed [127:0]     sum_ext;

   always_comb begin
      prod     = act * wt;
      prod_sh  = prod >>> FRAC;
      prod_ext = {{(ACC_W - PW){prod_sh[PW-1]}}, prod_sh};

      // load replaces stale contents so a new vector never inherits old sums
      acc_d = acc_q;
      if (load)     acc_d = prod_ext;
      else if (add) acc_d = acc_q + prod_ext;

      sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W + 1 - OUT_W){bias[OUT_W-1]}}, bias};
      if (relu && sum[ACC_W]) sum = '0;
      sum_ext = {{(127 - ACC_W){sum[ACC_W]}}, sum};
      res     = OUT_W'(sat_out(sum_ext, OUT_W));
   end

   always_ff @(posedge clk) begin
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d;
   end

endmodule

// File: rtl/fc_mac_pe.sv
// Fully-connected MAC processing element: LANES neurons share one activation
// stream, accumulate N_IN beats, then present a registered result vector.
// Handshakes: a transfer occurs on a cycle where valid && ready are both high;
// valid never waits on ready, and results stay stable while out_valid && !out_ready.
module fc_mac_pe
   import fc_pe_pkg::*;
#(
   parameter int N_IN  = 256,
   parameter int LANES = 4,
   parameter int ACT_W = 18,
   parameter int WT_W  = 16,
   parameter int OUT_W = 16,
   parameter int FRAC  = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ACT_W-1:0]       act,
   input  logic [LANES*WT_W-1:0]  wts,
   input  logic [LANES*OUT_W-1:0] bias,
   input  logic                   relu_en,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*OUT_W-1:0] dout,
   output logic [1:0]             state_dbg
);

   localparam int ACC_W = acc_width(ACT_W, WT_W, N_IN);
   localparam int CNT_W = $clog2(N_IN + 1);

   fc_state_e              state_d, state_q;
   logic [CNT_W-1:0]       cnt_d, cnt_q;
   logic                   relu_d, relu_q;
   logic [LANES*OUT_W-1:0] dout_d, dout_q;
   logic [LANES*OUT_W-1:0] lane_res;
   logic                   accept;
   logic                   load;
   logic                   add;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      fc_mac_lane #(
         .ACT_W(ACT_W), .WT_W(WT_W), .OUT_W(OUT_W), .FRAC(FRAC), .ACC_W(ACC_W)
      ) u_lane (
         .clk  (clk),
         .reset(reset),
         .load (load),
         .add  (add),
         .act  (act),
         .wt   (wts[k*WT_W +: WT_W]),
         .bias (bias[k*OUT_W +: OUT_W]),
         .relu (relu_q),
         .res  (lane_res[k*OUT_W +: OUT_W])
      );
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      relu_d   = relu_q;
      dout_d   = dout_q;
      load     = 1'b0;
      add      = 1'b0;
      in_ready = (state_q == IDLE) || (state_q == ACCUM);
      accept   = in_valid && in_ready;

      case (state_q)
         IDLE: begin
            if (accept) begin
               load    = 1'b1;
               cnt_d   = CNT_W'(1);
               relu_d  = relu_en;
               state_d = (N_IN == 1) ? FINISH : ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               add   = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(N_IN - 1)) state_d = FINISH;
            end
         end
         FINISH: begin
            dout_d  = lane_res;
            state_d = HOLD;
         end
         HOLD: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         relu_q  <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         relu_q  <= relu_d;
         dout_q  <= dout_d;
      end
   end

   assign out_valid = (state_q == HOLD);
   assign dout      = dout_q;
   assign state_dbg = state_q;

endmodule
